write_back_stage: RTL
=====================

// Module: write_back_stage
// PURPOSE
//  Parametrised write-back stage that replaces the 2:1 ALU/memory write-back select.
//  Registers the MEM/WB boundary and selects among NUM_SRC result sources.
//  Aligns and sign/zero-extends load data, and drives the register-file write port.
//  Sits between the data-memory stage and the register file; also reports retirement.
// PARAMETERS
//  XLEN        32  datapath width (32 only for load-align; other sources are width-generic)
//  NUM_SRC     4   number of write-back sources (2..8); source order is ALU, MEM, PC+4, IMM, ...
//  REG_AW      5   register address width
//  CNT_W       32  width of the retired-instruction counter
// PORTS
//  clk          in   1                    rising-edge clock
//  reset        in   1                    synchronous, active-high
//  in_valid     in   1                    MEM stage presents a valid instruction
//  stall        in   1                    hold WB register contents (hazard unit)
//  flush        in   1                    kill the instruction being captured this cycle
//  src_data     in   NUM_SRC*XLEN         packed sources; src i = [i*XLEN +: XLEN]
//  wb_sel       in   $clog2(NUM_SRC)      source select
//  is_load      in   1                    selected source is memory: apply load alignment
//  load_funct3  in   3                    000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//  addr_low     in   2                    byte offset of load address
//  rd_addr      in   REG_AW               destination register
//  reg_write    in   1                    instruction writes rd
//  rf_we        out  1                    register-file write enable
//  rf_waddr     out  REG_AW               register-file write address
//  rf_wdata     out  XLEN                 register-file write data
//  wb_valid     out  1                    WB register holds a live instruction
//  misalign_err out  1                    registered: LH/LHU at offset 3, LW at offset != 0
//  retired_cnt  out  CNT_W                count of retired instructions
// BEHAVIOUR
//  - Reset: all outputs = 0; WB register and counter cleared.
//  - Priority each edge: reset > flush > stall > capture.
//  - Capture (in_valid & !stall & !flush): the selected and aligned data, rd_addr, the write
//    flag and the error flag are registered.
//    Latency is 1 cycle from input to rf_* output.
//  - Register contents:
//    - wb_valid <= in_valid.
//    - rf_we <= reg_write & in_valid & (rd_addr != 0) & !err; x0 is never written.
//  - Stall without flush: all registered outputs hold their values, including rf_we.
//    The register file must tolerate a repeated identical write.
//  - Flush (with or without stall): wb_valid, rf_we and misalign_err go to 0.
//    rf_waddr and rf_wdata may hold stale values.
//  - !in_valid & !stall: bubble; wb_valid = 0 and rf_we = 0.
//  - wb_sel >= NUM_SRC: data = 0 and rf_we = 0 (illegal select is suppressed).
//  - Load align (is_load = 1, memory word m):
//    - byte lane b = m[8*addr_low +: 8];
//    - half h = m[16*addr_low[1] +: 16];
//    - LB sext(b), LBU zext(b), LH sext(h), LHU zext(h), LW m.
//    - Unsupported funct3 (011, 110, 111): data = 0 and rf_we = 0.
//  - Misalign (is_load only): LH/LHU with addr_low == 3, or LW with addr_low != 0.
//    misalign_err = 1 for that cycle's registered instruction, rf_we = 0, data = 0.
//  - Non-load path: the selected source is passed through unmodified; misalign_err = 0.
//  - retired_cnt increments by 1 on every edge where wb_valid = 1 and stall = 0.
//    Increments happen whether or not rf_we is set; the counter wraps 2^CNT_W-1 -> 0.
//    Reset clears it. A flush does not retract an already-counted instruction.
// TESTING
//  1. reset = 1 for 2 cycles -> all outputs 0; release with in_valid = 0 -> outputs stay 0.
//  2. ALU src = 0x0000_1234, wb_sel = 0, rd = 5, reg_write = 1
//     -> next cycle rf_we = 1, waddr = 5, wdata = 0x0000_1234.
//  3. Memory word 0x80FF_7F01, LB at offsets 0..3 -> 0x01, 0x7F, 0xFFFFFFFF, 0xFFFFFF80;
//     LHU at offset 2 -> 0x0000_80FF.
//  4. LW at addr_low = 2 -> misalign_err = 1, rf_we = 0, wdata = 0;
//     LH at offset 3 -> same result.
//  5. Stall held 3 cycles after capture -> outputs hold;
//     flush together with stall -> wb_valid = 0, rf_we = 0.
//  6. rd = 0, reg_write = 1 -> rf_we = 0, retired_cnt still increments;
//     with CNT_W = 4, preload 15 retirements -> next retirement wraps to 0.

Source files
------------

// File: rtl/write_back_stage_if.sv
// MEM/WB boundary bus: instruction results from the memory stage in,
// register-file write port and retirement status out.
interface write_back_stage_if #(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 4,
    parameter int REG_AW  = 5,
    parameter int CNT_W   = 32
);
    localparam int SEL_W = $clog2(NUM_SRC);

    logic                    in_valid;
    logic                    stall;
    logic                    flush;
    logic [NUM_SRC*XLEN-1:0] src_data;
    logic [SEL_W-1:0]        wb_sel;
    logic                    is_load;
    logic [2:0]              load_funct3;
    logic [1:0]              addr_low;
    logic [REG_AW-1:0]       rd_addr;
    logic                    reg_write;

    logic                    rf_we;
    logic [REG_AW-1:0]       rf_waddr;
    logic [XLEN-1:0]         rf_wdata;
    logic                    wb_valid;
    logic                    misalign_err;
    logic [CNT_W-1:0]        retired_cnt;

    modport master (
        output in_valid, stall, flush, src_data, wb_sel, is_load,
               load_funct3, addr_low, rd_addr, reg_write,
        input  rf_we, rf_waddr, rf_wdata, wb_valid, misalign_err, retired_cnt
    );

    modport slave (
        input  in_valid, stall, flush, src_data, wb_sel, is_load,
               load_funct3, addr_low, rd_addr, reg_write,
        output rf_we, rf_waddr, rf_wdata, wb_valid, misalign_err, retired_cnt
    );
endinterface

// File: rtl/write_back_stage.sv
// Write-back stage: registers the MEM/WB boundary, selects among NUM_SRC result
// sources, aligns/extends load data (XLEN = 32) and drives the register-file write port.
module write_back_stage #(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 4,
    parameter int REG_AW  = 5,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    write_back_stage_if.slave bus
);
    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_f3_e;

    logic [XLEN-1:0]   w_sel_data;
    logic              w_sel_ok;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [XLEN-1:0]   w_ld_data;
    logic              w_ld_ok;
    logic              w_mis;
    logic              w_ok;
    logic [XLEN-1:0]   w_data;
    logic              w_we;

    logic              r_valid;
    logic              r_we;
    logic              r_err;
    logic [REG_AW-1:0] r_waddr;
    logic [XLEN-1:0]   r_wdata;
    logic [CNT_W-1:0]  r_cnt;

    // Out-of-range selects leave w_sel_ok low so the write is suppressed.
    always_comb begin
        w_sel_data = '0;
        w_sel_ok   = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (32'(bus.wb_sel) == i) begin
                w_sel_data = bus.src_data[i*XLEN +: XLEN];
                w_sel_ok   = 1'b1;
            end
        end
    end

    always_comb begin
        w_byte = '0;
        case (bus.addr_low)
            2'd0:    w_byte = w_sel_data[7:0];
            2'd1:    w_byte = w_sel_data[15:8];
            2'd2:    w_byte = w_sel_data[23:16];
            default: w_byte = w_sel_data[31:24];
        endcase
        w_half = bus.addr_low[1] ? w_sel_data[31:16] : w_sel_data[15:0];

        w_ld_data = w_sel_data;
        w_ld_ok   = 1'b1;
        w_mis     = 1'b0;
        if (bus.is_load) begin
            case (bus.load_funct3)
                F3_LB:   w_ld_data = {{(XLEN-8){w_byte[7]}}, w_byte};
                F3_LBU:  w_ld_data = {{(XLEN-8){1'b0}}, w_byte};
                F3_LH: begin
                    w_ld_data = {{(XLEN-16){w_half[15]}}, w_half};
                    w_mis     = (bus.addr_low == 2'd3);
                end
                F3_LHU: begin
                    w_ld_data = {{(XLEN-16){1'b0}}, w_half};
                    w_mis     = (bus.addr_low == 2'd3);
                end
                F3_LW: begin
                    w_ld_data = w_sel_data;
                    w_mis     = (bus.addr_low != 2'd0);
                end
                default: begin
                    w_ld_data = '0;
                    w_ld_ok   = 1'b0;
                end
            endcase
        end

        w_ok   = w_sel_ok & w_ld_ok & ~w_mis;
        w_data = w_ok ? w_ld_data : '0;
        w_we   = bus.in_valid & bus.reg_write & (bus.rd_addr != '0) & w_ok;
    end

    // The counter looks at the pre-edge wb_valid, so a flush never retracts a retirement.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
        end else begin
            if (r_valid && !bus.stall) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (bus.flush) begin
                r_valid <= 1'b0;
                r_we    <= 1'b0;
                r_err   <= 1'b0;
            end else if (!bus.stall) begin
                r_valid <= bus.in_valid;
                r_we    <= w_we;
                r_err   <= bus.in_valid & w_mis;
                if (bus.in_valid) begin
                    r_waddr <= bus.rd_addr;
                    r_wdata <= w_data;
                end
            end
        end
    end

    assign bus.rf_we        = r_we;
    assign bus.rf_waddr     = r_waddr;
    assign bus.rf_wdata     = r_wdata;
    assign bus.wb_valid     = r_valid;
    assign bus.misalign_err = r_err;
    assign bus.retired_cnt  = r_cnt;
endmodule
